// File: rtl/phys_free_list.sv
// Physical register free list: 64-entry circular FIFO of tags, dual allocate / dual free.
// Optional duplicate-free detection bitmap enabled by defining FREE_LIST_DUP_CHECK_EN.
module phys_free_list #(
    parameter int unsigned NUM_PHYS = 64,
    parameter int unsigned NUM_ARCH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alloc_req_1,
    input  logic       alloc_req_2,
    output logic       alloc_gnt,
    output logic [5:0] alloc_pd_1,
    output logic [5:0] alloc_pd_2,
    input  logic       rt_flag_1,
    input  logic [5:0] fp_i_1,
    input  logic       rt_flag_2,
    input  logic [5:0] fp_i_2,
    output logic [6:0] free_count,
    output logic       empty,
    output logic       err_ovf,
    output logic       err_dup
);
    localparam int unsigned TagW = 6;
    localparam int unsigned CntW = 7;

    logic [TagW-1:0] mem_q [NUM_PHYS];
    logic [TagW-1:0] mem_d [NUM_PHYS];
    logic [TagW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic            ovf_q, ovf_d;

    logic [1:0]      n_req, n_pop, n_push;
    logic [TagW-1:0] head_p1, tail_p1;
    logic            v1, v2, dup1, dup2, ovf1, ovf2, push1, push2;

    always_comb begin
        head_p1    = head_q + TagW'(1);
        tail_p1    = tail_q + TagW'(1);
        n_req      = {1'b0, alloc_req_1} + {1'b0, alloc_req_2};
        alloc_gnt  = (n_req != 2'd0) && (count_q >= CntW'(n_req));
        alloc_pd_1 = mem_q[head_q];
        alloc_pd_2 = alloc_req_1 ? mem_q[head_p1] : mem_q[head_q];
        n_pop      = alloc_gnt ? n_req : 2'd0;
        free_count = count_q;
        empty      = (count_q == '0);
        err_ovf    = ovf_q;
    end

    // p0 is hardwired to x0 and never re-enters the list.
    assign v1 = rt_flag_1 && (fp_i_1 != '0);
    assign v2 = rt_flag_2 && (fp_i_2 != '0);

`ifdef FREE_LIST_DUP_CHECK_EN
    logic [NUM_PHYS-1:0] inlist_q, inlist_d;
    logic                dup_q, dup_d;

    assign dup1    = v1 && inlist_q[fp_i_1];
    assign dup2    = v2 && (inlist_q[fp_i_2] || (v1 && (fp_i_1 == fp_i_2)));
    assign err_dup = dup_q;

    always_comb begin
        inlist_d = inlist_q;
        if (n_pop != 2'd0) inlist_d[mem_q[head_q]] = 1'b0;
        if (n_pop == 2'd2) inlist_d[mem_q[head_p1]] = 1'b0;
        if (push1) inlist_d[fp_i_1] = 1'b1;
        if (push2) inlist_d[fp_i_2] = 1'b1;
        dup_d = dup_q | dup1 | dup2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PHYS; i++) inlist_q[i] <= (i >= NUM_ARCH);
            dup_q <= 1'b0;
        end else begin
            inlist_q <= inlist_d;
            dup_q    <= dup_d;
        end
    end
`else
    assign dup1    = 1'b0;
    assign dup2    = 1'b0;
    assign err_dup = 1'b0;
`endif

    // Full check counts only pushes ahead in this cycle; same-cycle pops do not make room.
    always_comb begin
        ovf1   = v1 && !dup1 && (count_q == CntW'(NUM_PHYS));
        push1  = v1 && !dup1 && !ovf1;
        ovf2   = v2 && !dup2 && ((count_q + CntW'(push1)) == CntW'(NUM_PHYS));
        push2  = v2 && !dup2 && !ovf2;
        n_push = {1'b0, push1} + {1'b0, push2};

        mem_d = mem_q;
        if (push1) mem_d[tail_q] = fp_i_1;
        if (push2) mem_d[push1 ? tail_p1 : tail_q] = fp_i_2;

        head_d  = head_q + TagW'(n_pop);
        tail_d  = tail_q + TagW'(n_push);
        count_d = count_q + CntW'(n_push) - CntW'(n_pop);
        ovf_d   = ovf_q | ovf1 | ovf2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PHYS; i++) begin
                mem_q[i] <= (i < NUM_PHYS - NUM_ARCH) ? TagW'(NUM_ARCH + i) : '0;
            end
            head_q  <= '0;
            tail_q  <= TagW'(NUM_PHYS - NUM_ARCH);
            count_q <= CntW'(NUM_PHYS - NUM_ARCH);
            ovf_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_phys_free_list.sv
// Self-checking bench for phys_free_list: queue-based reference model, directed and random stimulus.
module tb_phys_free_list;
`ifdef FREE_LIST_DUP_CHECK_EN
    localparam bit DUP = 1'b1;
`else
    localparam bit DUP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       r1, r2, f1, f2;
    logic [5:0] p1, p2;
    logic       gnt, empty, ovf, dup;
    logic [5:0] pd1, pd2;
    logic [6:0] fc;

    int checks = 0;
    int passed = 0;
    int total_pops = 0;
    int q[$];
    int outst[$];
    bit m_ovf, m_dup;

    always #5 clk = ~clk;

    phys_free_list dut (
        .clk        (clk),
        .rst        (rst),
        .alloc_req_1(r1),
        .alloc_req_2(r2),
        .alloc_gnt  (gnt),
        .alloc_pd_1 (pd1),
        .alloc_pd_2 (pd2),
        .rt_flag_1  (f1),
        .fp_i_1     (p1),
        .rt_flag_2  (f2),
        .fp_i_2     (p2),
        .free_count (fc),
        .empty      (empty),
        .err_ovf    (ovf),
        .err_dup    (dup)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic bit in_q(input int t);
        foreach (q[i]) if (q[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void remove_outst(input int t);
        foreach (outst[i]) if (outst[i] == t) begin
            outst.delete(i);
            return;
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        outst.delete();
        for (int i = 0; i < 32; i++) q.push_back(32 + i);
        for (int i = 1; i < 32; i++) outst.push_back(i);
        m_ovf = 1'b0;
        m_dup = 1'b0;
    endfunction

    task automatic drive(input bit a1, input bit a2, input bit e1, input int t1,
                         input bit e2, input int t2);
        r1 = a1; r2 = a2; f1 = e1; p1 = 6'(t1); f2 = e2; p2 = 6'(t2);
    endtask

    // Combinational outputs against the model, taken between clock edges.
    task automatic compare();
        int n;
        bit eg;
        n  = int'(r1) + int'(r2);
        eg = (n > 0) && (q.size() >= n);
        chk("alloc_gnt", int'(gnt), int'(eg));
        if (eg && r1) chk("alloc_pd_1", int'(pd1), q[0]);
        if (eg && r2) chk("alloc_pd_2", int'(pd2), r1 ? q[1] : q[0]);
        chk("free_count", int'(fc), q.size());
        chk("empty", int'(empty), int'(q.size() == 0));
        chk("err_ovf", int'(ovf), int'(m_ovf));
        chk("err_dup", int'(dup), int'(m_dup));
    endtask

    task automatic model_edge();
        int n, c0;
        int acc[$];
        bit g, v1, v2;
        n  = int'(r1) + int'(r2);
        g  = (n > 0) && (q.size() >= n);
        c0 = q.size();
        v1 = f1 && (p1 != 0);
        v2 = f2 && (p2 != 0);
        if (v1) begin
            if (DUP && in_q(int'(p1))) m_dup = 1'b1;
            else if (c0 == 64) m_ovf = 1'b1;
            else acc.push_back(int'(p1));
        end
        if (v2) begin
            if (DUP && (in_q(int'(p2)) || (v1 && p1 == p2))) m_dup = 1'b1;
            else if (c0 + acc.size() == 64) m_ovf = 1'b1;
            else acc.push_back(int'(p2));
        end
        if (g) for (int i = 0; i < n; i++) begin
            outst.push_back(q.pop_front());
            total_pops++;
        end
        foreach (acc[i]) q.push_back(acc[i]);
    endtask

    task automatic cyc_a();
        #1;
        compare();
    endtask

    task automatic cyc_b();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick_free();
        int idx, t;
        if (($urandom % 16) == 0 || outst.size() == 0) return int'($urandom_range(0, 63));
        idx = int'($urandom_range(0, outst.size() - 1));
        t   = outst[idx];
        outst.delete(idx);
        return t;
    endfunction

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        do_reset();

        cyc_a();
        chk("reset free_count", int'(fc), 32);
        chk("reset gnt", int'(gnt), 0);
        chk("reset empty", int'(empty), 0);
        chk("reset err_ovf", int'(ovf), 0);

        // Dual allocate out of reset.
        drive(1, 1, 0, 0, 0, 0);
        cyc_a();
        chk("first pd_1", int'(pd1), 32);
        chk("first pd_2", int'(pd2), 33);
        chk("first gnt", int'(gnt), 1);
        cyc_b();
        drive(0, 0, 0, 0, 0, 0);
        cyc_a();
        chk("count after first", int'(fc), 30);

        // Drain to empty, then a request must be refused.
        for (int i = 0; i < 15; i++) begin
            drive(1, 1, 0, 0, 0, 0);
            cyc_a();
            cyc_b();
        end
        drive(1, 0, 0, 0, 0, 0);
        cyc_a();
        chk("drained empty", int'(empty), 1);
        chk("empty gnt", int'(gnt), 0);
        cyc_b();
        drive(0, 0, 0, 0, 0, 0);
        cyc_a();
        chk("empty count stays", int'(fc), 0);

        // No same-cycle bypass of a freed tag.
        remove_outst(40);
        drive(1, 0, 1, 40, 0, 0);
        cyc_a();
        chk("bypass gnt", int'(gnt), 0);
        cyc_b();
        drive(1, 0, 0, 0, 0, 0);
        cyc_a();
        chk("freed pd_1", int'(pd1), 40);
        chk("freed gnt", int'(gnt), 1);
        cyc_b();

        // One entry, two requests: all-or-nothing; p0 free ignored.
        remove_outst(41);
        drive(0, 0, 1, 41, 0, 0);
        cyc_a();
        cyc_b();
        drive(1, 1, 0, 0, 0, 0);
        cyc_a();
        chk("partial gnt", int'(gnt), 0);
        cyc_b();
        drive(0, 0, 1, 0, 0, 0);
        cyc_a();
        cyc_b();
        drive(1, 0, 0, 0, 0, 0);
        cyc_a();
        chk("p0 count", int'(fc), 1);
        chk("head kept", int'(pd1), 41);
        cyc_b();

        // Free of a tag already in the list.
        do_reset();
        drive(0, 0, 1, 45, 0, 0);
        cyc_a();
        cyc_b();
        drive(0, 0, 0, 0, 0, 0);
        cyc_a();
        chk("dup free count", int'(fc), DUP ? 32 : 33);
        chk("dup free flag", int'(dup), DUP ? 1 : 0);

        // Random traffic with phases biased toward filling, draining and balance.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            int ar, fr;
            bit a1, a2, e1, e2;
            int t1, t2;
            ar = ((c / 250) % 3 == 0) ? 30 : (((c / 250) % 3 == 1) ? 80 : 55);
            fr = 100 - ar;
            a1 = ($urandom_range(0, 99) < ar);
            a2 = ($urandom_range(0, 99) < ar);
            e1 = ($urandom_range(0, 99) < fr);
            e2 = ($urandom_range(0, 99) < fr);
            t1 = e1 ? pick_free() : int'($urandom_range(0, 63));
            t2 = e2 ? pick_free() : int'($urandom_range(0, 63));
            drive(a1, a2, e1, t1, e2, t2);
            cyc_a();
            if (c == 2222) begin
                // Asynchronous reset mid-cycle discards this cycle's traffic.
                drive(0, 0, 0, 0, 0, 0);
                rst = 1'b1;
                #1;
                chk("async rst count", int'(fc), 32);
                chk("async rst ovf", int'(ovf), 0);
                chk("async rst dup", int'(dup), 0);
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                model_reset();
                @(posedge clk);
                #1;
            end else begin
                cyc_b();
            end
        end
        chk("head wrapped 3x", int'(total_pops >= 192), 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/phys_free_list.md
PHYS_FREE_LIST -- requirements
Module: phys_free_list

Interface
REQ-001 Parameter: NUM_PHYS, 64, total physical registers; fixes 6-bit tag width.
REQ-002 Parameter: NUM_ARCH, 32, architectural registers; p0..p(NUM_ARCH-1) are mapped at reset.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 alloc_req_1  in  1  rename requests one tag for instruction 1.
REQ-006 alloc_req_2  in  1  rename requests one tag for instruction 2.
REQ-007 alloc_gnt  out  1  requested tags available this cycle; pop occurs at the clock edge.
REQ-008 alloc_pd_1  out  6  tag for instruction 1; equals the head entry.
REQ-009 alloc_pd_2  out  6  tag for instruction 2; head+1 if alloc_req_1 is set, else the head.
REQ-010 rt_flag_1 / fp_i_1  in  1 / 6  retire slot 1 frees its old physical register.
REQ-011 rt_flag_2 / fp_i_2  in  1 / 6  retire slot 2 frees its old physical register.
REQ-012 free_count  out  7  number of entries in the list (0..64).
REQ-013 empty  out  1  free_count == 0.
REQ-014 err_ovf  out  1  sticky; a push was attempted while the list was full.
REQ-015 err_dup  out  1  sticky; a duplicate free was detected (see Configuration).

Function
REQ-016 Storage: circular FIFO, 64 entries x 6 bits, with a 6-bit head pointer, a 6-bit tail pointer and a 7-bit count; both pointers wrap from 63 to 0.
REQ-017 alloc_pd_1, alloc_pd_2 and alloc_gnt are combinational from head, count and the requests, so the tags are valid in the cycle they are requested.
REQ-018 alloc_gnt is all-or-nothing: it is 1 only when count >= (alloc_req_1 + alloc_req_2).
REQ-019 When alloc_gnt=1, the head advances by the number of requests at the edge; when alloc_gnt=0, no pop occurs.
REQ-020 With no request, alloc_gnt=0 and the pointers are unchanged.
REQ-021 Frees push at the tail, slot 1 first then slot 2; tail advances by the number of accepted pushes.
REQ-022 A free with fp_i=0 is ignored, since p0 is hardwired to x0 and never recycled.
REQ-023 A tag freed in cycle N is not allocatable before cycle N+1; no same-cycle bypass.
REQ-024 Simultaneous allocation and free: next count = count + pushes - pops, evaluated in one edge.
REQ-025 Full boundary: a push when count + earlier pushes in the same cycle == 64 is dropped and sets err_ovf.
REQ-026 Empty boundary: requests when empty give alloc_gnt=0, and alloc_pd_* are don't-care.
REQ-027 The 6-bit tag wrap is modulo 64; count never exceeds 64 and never goes below 0.

Reset
REQ-028 Asynchronous assertion of rst clears all state immediately; rst deassertion is synchronous to clk.
REQ-029 Reset contents: entry i holds NUM_ARCH+i for i=0..31; head=0, tail=32, count=32.
REQ-030 Reset outputs: alloc_gnt=0, empty=0, err_ovf=0, err_dup=0.
REQ-031 rst mid-operation discards all in-flight allocations and frees; no partial push or pop completes.

Configuration
REQ-032 Macro FREE_LIST_DUP_CHECK_EN, when defined, adds a 64-bit in-list bitmap.
REQ-033 Bitmap maintenance: a bit is set on push, cleared on pop, and reset to 1 for p32..p63 only.
REQ-034 With the macro defined, a free of a tag whose bit is already set is dropped and sets err_dup.
REQ-035 With the macro defined, fp_i_1 == fp_i_2 with both flags set pushes once and sets err_dup.
REQ-036 With the macro undefined, there is no bitmap, every valid free is pushed, and err_dup is tied 0.

Verification
REQ-037 Reset, then alloc_req_1=alloc_req_2=1 -> alloc_pd_1=32, alloc_pd_2=33, alloc_gnt=1; next cycle free_count=30.
REQ-038 Allocate 32 tags in 16 cycles -> empty=1; then alloc_req_1=1 -> alloc_gnt=0 and free_count stays 0.
REQ-039 Empty list, rt_flag_1=1 with fp_i_1=40 and alloc_req_1=1 in the same cycle -> alloc_gnt=0; next cycle alloc_pd_1=40, alloc_gnt=1.
REQ-040 free_count=1 with both requests set -> alloc_gnt=0 and the head is unchanged; rt_flag_1=1 with fp_i_1=0 -> count unchanged.
REQ-041 Cycle the list through 3 full wrap-arounds of head and tail -> tags are returned in FIFO order with no loss or duplication.
REQ-042 With FREE_LIST_DUP_CHECK_EN defined, after reset free fp_i_1=45 -> dropped, err_dup=1, free_count=32; with the macro undefined, the same stimulus gives free_count=33 and err_dup=0.
